// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_wb_arbiter_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int MAX_WAIT_DEF = 4;

    // Which requester owns the register-file write port this cycle.
    // Also decoded by hazard-unit debug logic.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_HOLD = 2'd2
    } gnt_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of pipeline WB, multi-cycle unit, register-file port and hazard-unit signals.
// Latency: n/a (wiring only).
// Backpressure: mc_ready throttles the multi-cycle unit, stall_pipe freezes the pipeline.
interface reg_wb_arbiter_if
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    // pipeline writeback stage
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              stall_pipe;
    // multi-cycle execution unit
    logic              mc_valid;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic              mc_ready;
    // register-file write port
    logic              regwrite;
    logic [ADDR_W-1:0] REG_address_wb;
    logic [DATA_W-1:0] data_wb;
    // hazard-unit view of the holding slot
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;

    // Requester side: drives requests, observes the arbiter results.
    modport master (
        output wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
        input  stall_pipe, mc_ready, regwrite, REG_address_wb, data_wb,
        input  pend_valid, pend_addr
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
        output stall_pipe, mc_ready, regwrite, REG_address_wb, data_wb,
        output pend_valid, pend_addr
    );
endinterface

// File: rtl/reg_wb_arbiter_wb_hold_slot.sv
// One-entry holding slot for multi-cycle results with a saturating starvation counter.
// Latency: load visible one cycle after the mc_valid/mc_ready edge.
// Backpressure: accepts a load only when empty (caller gates with !o_hold_valid).
module wb_hold_slot
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  gnt_e              i_gnt,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_mc_addr,
    input  logic [DATA_W-1:0] i_mc_data,
    output logic              o_hold_valid,
    output logic [ADDR_W-1:0] o_hold_addr,
    output logic [DATA_W-1:0] o_hold_data,
    output logic              o_starved
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_wait_cnt;
    logic              w_squash;

    // A younger pipeline write to the same (non-r0) register makes the held result dead.
    assign w_squash = r_valid && (i_gnt == GNT_WB) && (i_wb_addr == r_addr) && (r_addr != '0);

    // Slot drain/squash/age, then load; a load only happens when the slot started empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wait_cnt <= 4'd0;
        end else begin
            if ((i_gnt == GNT_HOLD) || w_squash) begin
                r_valid    <= 1'b0;
                r_wait_cnt <= 4'd0;
            end else if (r_valid && (r_wait_cnt != MAX_CNT)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
            if (i_load) begin
                r_valid    <= 1'b1;
                r_addr     <= i_mc_addr;
                r_data     <= i_mc_data;
                r_wait_cnt <= 4'd0;
            end
        end
    end

    assign o_hold_valid = r_valid;
    assign o_hold_addr  = r_addr;
    assign o_hold_data  = r_data;
    // Purely registered, so stall_pipe has no combinational path from any input.
    assign o_starved    = r_valid && (r_wait_cnt == MAX_CNT);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage (priority) and the mult/div slot.
// Latency: zero-cycle grant to the register file; held results written within MAX_WAIT+1 cycles.
// Backpressure: mc_ready low while the slot is full; stall_pipe freezes WB when the slot is starved.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    reg_wb_arbiter_if.slave bus
);

    gnt_e              w_gnt;
    logic              w_hold_valid;
    logic [ADDR_W-1:0] w_hold_addr;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_starved;
    logic              w_stall;
    logic              w_mc_ready;
    logic              w_load;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_stall    = reset && w_starved;
    assign w_mc_ready = reset && !w_hold_valid;
    assign w_load     = bus.mc_valid && w_mc_ready;

    // Grant priority: forced drain of a starved slot, then WB, then an idle-port drain.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!reset)            w_gnt = GNT_NONE;
        else if (w_stall)      w_gnt = GNT_HOLD;
        else if (bus.wb_valid) w_gnt = GNT_WB;
        else if (w_hold_valid) w_gnt = GNT_HOLD;
    end

    // Write-port mux; an idle port presents zeros.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        case (w_gnt)
            GNT_WB: begin
                w_sel_addr = bus.wb_addr;
                w_sel_data = bus.wb_data;
            end
            GNT_HOLD: begin
                w_sel_addr = w_hold_addr;
                w_sel_data = w_hold_data;
            end
            default: begin
                w_sel_addr = '0;
                w_sel_data = '0;
            end
        endcase
    end

    wb_hold_slot #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_slot (
        .clk          (clk),
        .reset        (reset),
        .i_gnt        (w_gnt),
        .i_wb_addr    (bus.wb_addr),
        .i_load       (w_load),
        .i_mc_addr    (bus.mc_addr),
        .i_mc_data    (bus.mc_data),
        .o_hold_valid (w_hold_valid),
        .o_hold_addr  (w_hold_addr),
        .o_hold_data  (w_hold_data),
        .o_starved    (w_starved)
    );

    // r0 writes still consume the grant but never reach the register file.
    assign bus.regwrite       = (w_gnt != GNT_NONE) && (w_sel_addr != '0);
    assign bus.REG_address_wb = w_sel_addr;
    assign bus.data_wb        = w_sel_data;
    assign bus.stall_pipe     = w_stall;
    assign bus.mc_ready       = w_mc_ready;
    assign bus.pend_valid     = reset && w_hold_valid;
    assign bus.pend_addr      = (reset && w_hold_valid) ? w_hold_addr : '0;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus random traffic vs a queue model.
// Latency: outputs sampled on the falling edge, model advanced at the rising edge.
// Backpressure: the model honours mc_ready and stall_pipe exactly as the requesters must.
module tb_reg_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic clk;
    logic reset;

    reg_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending results as a queue, starvation as a count of denied cycles.
    ent_t slot_q[$];
    int   denied;
    int   e_src;            // 0 none, 1 pipeline, 2 held result
    logic          e_regwrite, e_stall, e_mc_ready, e_pend_valid;
    logic [AW-1:0] e_addr, e_pend_addr;
    logic [DW-1:0] e_data;

    function automatic void model_clear();
        slot_q.delete();
        denied = 0;
    endfunction

    function automatic void model_eval();
        bit busy;
        busy = (slot_q.size() != 0);
        e_src = 0; e_regwrite = 0; e_stall = 0; e_mc_ready = 0;
        e_pend_valid = 0; e_pend_addr = '0; e_addr = '0; e_data = '0;
        if (reset) begin
            e_stall      = busy && (denied >= MW);
            e_mc_ready   = !busy;
            e_pend_valid = busy;
            if (busy) e_pend_addr = slot_q[0].addr;
            if (e_stall)           e_src = 2;
            else if (bus.wb_valid) e_src = 1;
            else if (busy)         e_src = 2;
            if (e_src == 1) begin e_addr = bus.wb_addr;    e_data = bus.wb_data;    end
            if (e_src == 2) begin e_addr = slot_q[0].addr; e_data = slot_q[0].data; end
            e_regwrite = (e_src != 0) && (e_addr != 0);
        end
    endfunction

    // Apply what the coming rising edge does to the pending result.
    function automatic void model_commit();
        bit busy;
        bit gone;
        model_eval();
        if (!reset) begin
            model_clear();
            return;
        end
        busy = (slot_q.size() != 0);
        gone = (e_src == 2) ||
               (e_src == 1 && busy && bus.wb_addr == slot_q[0].addr && bus.wb_addr != 0);
        if (gone) begin
            void'(slot_q.pop_front());
            denied = 0;
        end else if (busy) begin
            denied = (denied + 1 > MW) ? MW : denied + 1;
        end
        if (bus.mc_valid && e_mc_ready) begin
            slot_q.push_back('{addr: bus.mc_addr, data: bus.mc_data});
            denied = 0;
        end
    endfunction

    task automatic idle_inputs();
        bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.mc_valid = 0; bus.mc_addr = '0; bus.mc_data = '0;
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        model_clear();
        idle_inputs();
        bus.wb_valid = 1; bus.wb_addr = 5; bus.wb_data = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.regwrite !== 1'b0) begin n_errors++; $display("FAIL reset_regwrite got %b expected 0", bus.regwrite); end
        n_checks++; if (bus.mc_ready !== 1'b0) begin n_errors++; $display("FAIL reset_mc_ready got %b expected 0", bus.mc_ready); end
        n_checks++; if (bus.stall_pipe !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b expected 0", bus.stall_pipe); end
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.pend_addr !== '0) begin n_errors++; $display("FAIL reset_pend got %b/%0d expected 0/0", bus.pend_valid, bus.pend_addr); end
        reset = 1;
        #1;
        n_checks++; if (bus.mc_ready !== 1'b1) begin n_errors++; $display("FAIL release_mc_ready got %b expected 1", bus.mc_ready); end
        n_checks++; if (bus.regwrite !== 1'b1 || bus.REG_address_wb !== 5) begin n_errors++; $display("FAIL release_wb got we=%b addr=%0d expected we=1 addr=5", bus.regwrite, bus.REG_address_wb); end
        advance();
        idle_inputs();
    endtask

    task automatic test_wb_path();
        bus.wb_valid = 1; bus.wb_addr = 5; bus.wb_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({bus.regwrite, bus.REG_address_wb, bus.data_wb} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            n_errors++; $display("FAIL wb_path got we=%b addr=%0d data=%h expected we=1 addr=5 data=deadbeef", bus.regwrite, bus.REG_address_wb, bus.data_wb);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_mc_path();
        bus.mc_valid = 1; bus.mc_addr = 7; bus.mc_data = 32'h1234;
        @(negedge clk);
        n_checks++; if (bus.mc_ready !== 1'b1 || bus.regwrite !== 1'b0) begin n_errors++; $display("FAIL mc_c0 got rdy=%b we=%b expected rdy=1 we=0", bus.mc_ready, bus.regwrite); end
        advance();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (bus.mc_ready !== 1'b0 || bus.pend_valid !== 1'b1 || bus.pend_addr !== 7) begin n_errors++; $display("FAIL mc_c1_slot got rdy=%b pend=%b/%0d expected rdy=0 pend=1/7", bus.mc_ready, bus.pend_valid, bus.pend_addr); end
        n_checks++; if ({bus.regwrite, bus.REG_address_wb, bus.data_wb} !== {1'b1, 5'd7, 32'h1234}) begin n_errors++; $display("FAIL mc_c1_write got we=%b addr=%0d data=%h expected we=1 addr=7 data=1234", bus.regwrite, bus.REG_address_wb, bus.data_wb); end
        advance();
        @(negedge clk);
        n_checks++; if (bus.mc_ready !== 1'b1 || bus.pend_valid !== 1'b0) begin n_errors++; $display("FAIL mc_c2 got rdy=%b pend=%b expected rdy=1 pend=0", bus.mc_ready, bus.pend_valid); end
        advance();
    endtask

    task automatic test_starvation();
        bus.mc_valid = 1; bus.mc_addr = 9; bus.mc_data = 32'h99;
        advance();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            bus.wb_valid = 1; bus.wb_addr = 5'(i); bus.wb_data = 32'(i * 16);
            @(negedge clk);
            n_checks++;
            if ({bus.stall_pipe, bus.regwrite, bus.REG_address_wb} !== {1'b0, 1'b1, 5'(i)}) begin
                n_errors++; $display("FAIL starve_wb%0d got stall=%b we=%b addr=%0d expected stall=0 we=1 addr=%0d", i, bus.stall_pipe, bus.regwrite, bus.REG_address_wb, i);
            end
            advance();
        end
        bus.wb_valid = 1; bus.wb_addr = 5; bus.wb_data = 32'h50;
        @(negedge clk);
        n_checks++;
        if ({bus.stall_pipe, bus.regwrite, bus.REG_address_wb, bus.data_wb} !== {1'b1, 1'b1, 5'd9, 32'h99}) begin
            n_errors++; $display("FAIL starve_force got stall=%b we=%b addr=%0d data=%h expected stall=1 we=1 addr=9 data=99", bus.stall_pipe, bus.regwrite, bus.REG_address_wb, bus.data_wb);
        end
        advance();
        @(negedge clk);
        n_checks++;
        if ({bus.stall_pipe, bus.regwrite, bus.REG_address_wb, bus.pend_valid} !== {1'b0, 1'b1, 5'd5, 1'b0}) begin
            n_errors++; $display("FAIL starve_after got stall=%b we=%b addr=%0d pend=%b expected stall=0 we=1 addr=5 pend=0", bus.stall_pipe, bus.regwrite, bus.REG_address_wb, bus.pend_valid);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_squash();
        bus.mc_valid = 1; bus.mc_addr = 3; bus.mc_data = 32'h5555;
        advance();
        idle_inputs();
        bus.wb_valid = 1; bus.wb_addr = 3; bus.wb_data = 32'hAAAA;
        @(negedge clk);
        n_checks++;
        if ({bus.regwrite, bus.REG_address_wb, bus.data_wb} !== {1'b1, 5'd3, 32'hAAAA}) begin
            n_errors++; $display("FAIL squash_write got we=%b addr=%0d data=%h expected we=1 addr=3 data=aaaa", bus.regwrite, bus.REG_address_wb, bus.data_wb);
        end
        advance();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.pend_valid !== 1'b0 || bus.regwrite !== 1'b0 || bus.data_wb === 32'h5555) begin
                n_errors++; $display("FAIL squash_gone%0d got pend=%b we=%b data=%h expected pend=0 we=0 data!=5555", i, bus.pend_valid, bus.regwrite, bus.data_wb);
            end
            advance();
        end
    endtask

    task automatic test_r0();
        bus.wb_valid = 1; bus.wb_addr = 0; bus.wb_data = 32'hFFFF;
        @(negedge clk);
        n_checks++; if (bus.regwrite !== 1'b0) begin n_errors++; $display("FAIL r0_wb got we=%b expected 0", bus.regwrite); end
        advance();
        idle_inputs();
        bus.mc_valid = 1; bus.mc_addr = 0; bus.mc_data = 32'h77;
        advance();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({bus.pend_valid, bus.pend_addr, bus.regwrite, bus.mc_ready} !== {1'b1, 5'd0, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL r0_drain got pend=%b/%0d we=%b rdy=%b expected pend=1/0 we=0 rdy=0", bus.pend_valid, bus.pend_addr, bus.regwrite, bus.mc_ready);
        end
        advance();
        @(negedge clk);
        n_checks++; if (bus.pend_valid !== 1'b0 || bus.mc_ready !== 1'b1) begin n_errors++; $display("FAIL r0_free got pend=%b rdy=%b expected pend=0 rdy=1", bus.pend_valid, bus.mc_ready); end
        advance();
    endtask

    task automatic test_random();
        logic [45:0] got, exp;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.wb_valid = ($urandom_range(0, 99) < 60);
            bus.wb_addr  = 5'($urandom_range(0, 7));
            bus.wb_data  = $urandom;
            bus.mc_valid = ($urandom_range(0, 99) < 45);
            bus.mc_addr  = 5'($urandom_range(0, 7));
            bus.mc_data  = $urandom;
            if ($urandom_range(0, 99) < 2) begin
                reset = 0;
                model_clear();
            end else begin
                reset = 1;
            end
            @(negedge clk);
            model_eval();
            got = {bus.regwrite, bus.REG_address_wb, bus.data_wb, bus.stall_pipe,
                   bus.mc_ready, bus.pend_valid, bus.pend_addr};
            exp = {e_regwrite, e_addr, e_data, e_stall, e_mc_ready, e_pend_valid, e_pend_addr};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random cyc=%0d got we=%b a=%0d d=%h st=%b rdy=%b pv=%b pa=%0d expected we=%b a=%0d d=%h st=%b rdy=%b pv=%b pa=%0d",
                         cyc, got[45], got[44:40], got[39:8], got[7], got[6], got[5], got[4:0],
                         exp[45], exp[44:40], exp[39:8], exp[7], exp[6], exp[5], exp[4:0]);
            end
            advance();
        end
        reset = 1;
        idle_inputs();
        advance();
    endtask

    initial begin
        idle_inputs();
        model_clear();
        test_reset();
        test_wb_path();
        test_mc_path();
        test_starvation();
        test_squash();
        test_r0();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
